// File: rtl/fetch_pkg.sv
// fetch_pkg: shared FSM state type, instruction field positions and buffer
// sizing for the instruction fetch unit.
// Build option FETCH_PREFETCH_EN: when defined the fetch buffer holds two
// entries so fetching continues while decode stalls; otherwise one entry.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_t;

    localparam int OP_HI   = 31;
    localparam int OP_LO   = 26;
    localparam int FUNC_HI = 5;
    localparam int FUNC_LO = 0;
    localparam int PC_STEP = 4;

`ifdef FETCH_PREFETCH_EN
    localparam int FETCH_DEPTH = 2;
`else
    localparam int FETCH_DEPTH = 1;
`endif

    localparam int FETCH_CNT_W = $clog2(FETCH_DEPTH + 1);

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small {instr, pc} buffer between memory responses and decode.
// Entry 0 is always the head; a pop shifts the remaining entries down, so the
// write slot is simply the occupancy after this cycle's pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_push,
    input  logic [31:0]       i_push_instr,
    input  logic [ADDR_W-1:0] i_push_pc,
    input  logic              i_pop,
    input  logic              i_flush,
    output logic [CNT_W-1:0]  o_count,
    output logic [31:0]       o_head_instr,
    output logic [ADDR_W-1:0] o_head_pc
);

    logic [31:0]       r_instr [DEPTH];
    logic [ADDR_W-1:0] r_pc    [DEPTH];
    logic [CNT_W-1:0]  r_count;
    int                w_wr_idx;

    // Slot the incoming entry lands in, accounting for a same-cycle pop.
    always_comb begin
        w_wr_idx = int'(r_count) - (i_pop ? 1 : 0);
    end

    // Occupancy: flush empties the buffer and discards any same-cycle push.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_flush) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
        end
    end

    // Entry storage: shift on pop, then write the new entry at its slot.
    always_ff @(posedge clock) begin
        if (i_pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                r_instr[i] <= r_instr[i+1];
                r_pc[i]    <= r_pc[i+1];
            end
        end
        if (i_push && !i_flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i == w_wr_idx) begin
                    r_instr[i] <= i_push_instr;
                    r_pc[i]    <= i_push_pc;
                end
            end
        end
    end

    assign o_count      = r_count;
    assign o_head_instr = r_instr[0];
    assign o_head_pc    = r_pc[0];

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: issues one outstanding word fetch at a time, buffers responses
// with their PC for the decode controller, and restarts on redirect.
// A redirect while a request is outstanding moves to FLUSH: the request stays
// on the bus unchanged until acked, its data is dropped, and fetch resumes at
// the saved target.
// Build option FETCH_PREFETCH_EN (see fetch_pkg) sets the buffer depth.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h0000_0000)
) (
    input  logic              clock,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr,
    output logic [5:0]        op,
    output logic [5:0]        func,
    output logic [ADDR_W-1:0] instr_pc
);

    localparam int CNT_W = FETCH_CNT_W;

    fetch_state_t      r_state;
    fetch_state_t      w_state_next;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_tgt;
    logic [ADDR_W-1:0] w_pc_next;
    logic [ADDR_W-1:0] w_tgt_next;
    logic [ADDR_W-1:0] w_redirect_tgt;
    logic              w_push;
    logic              w_pop;
    logic              w_flush;
    logic              w_space;
    logic [CNT_W-1:0]  w_count;
    logic [CNT_W-1:0]  w_cnt_after;
    logic [31:0]       w_head_instr;
    logic [ADDR_W-1:0] w_head_pc;

    assign w_redirect_tgt = redirect_pc & ~ADDR_W'(3);
    assign instr_valid    = (w_count != '0);
    assign w_pop          = instr_valid && instr_ready;

    fetch_fifo #(
        .DEPTH  (FETCH_DEPTH),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_fifo (
        .clock        (clock),
        .reset        (reset),
        .i_push       (w_push),
        .i_push_instr (imem_rdata),
        .i_push_pc    (r_pc),
        .i_pop        (w_pop),
        .i_flush      (w_flush),
        .o_count      (w_count),
        .o_head_instr (w_head_instr),
        .o_head_pc    (w_head_pc)
    );

    // Next-state, PC update, buffer control and request output.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_tgt_next   = r_tgt;
        w_push       = 1'b0;
        w_flush      = 1'b0;
        w_cnt_after  = '0;
        w_space      = 1'b0;
        imem_req     = (r_state != ST_IDLE);

        // A redirect always empties the buffer. With no request in flight, or
        // when the in-flight one completes now, the new PC takes effect at
        // once; otherwise it is parked until the old response arrives.
        if (redirect) begin
            w_flush = 1'b1;
            if (r_state == ST_IDLE || imem_ack) begin
                w_pc_next = w_redirect_tgt;
            end else begin
                w_tgt_next = w_redirect_tgt;
            end
        end else if (imem_ack && r_state == ST_REQ) begin
            w_push    = 1'b1;
            w_pc_next = r_pc + ADDR_W'(PC_STEP);
        end else if (imem_ack && r_state == ST_FLUSH) begin
            w_pc_next = r_tgt;
        end

        // Request again next cycle only if buffered plus in-flight fits.
        if (w_flush) begin
            w_cnt_after = '0;
        end else begin
            w_cnt_after = w_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
        w_space = (w_cnt_after < CNT_W'(FETCH_DEPTH));

        unique case (r_state)
            ST_IDLE: begin
                if (w_space) begin
                    w_state_next = ST_REQ;
                end
            end
            ST_REQ, ST_FLUSH: begin
                if (imem_ack) begin
                    w_state_next = w_space ? ST_REQ : ST_IDLE;
                end else if (redirect) begin
                    w_state_next = ST_FLUSH;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Fetch address and parked redirect target.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pc  <= RESET_PC;
            r_tgt <= RESET_PC;
        end else begin
            r_pc  <= w_pc_next;
            r_tgt <= w_tgt_next;
        end
    end

    assign imem_addr = r_pc;
    assign instr     = instr_valid ? w_head_instr : 32'h0;
    assign instr_pc  = instr_valid ? w_head_pc : '0;
    assign op        = instr[OP_HI:OP_LO];
    assign func      = instr[FUNC_HI:FUNC_LO];

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed vectors for instr_fetch. The memory model returns
// the bitwise inverse of the requested address as the instruction word.
`timescale 1ns/1ps
module tb_instr_fetch;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [5:0]  func;
    logic [31:0] instr_pc;

    int total = 0;
    int bad   = 0;

`ifdef FETCH_PREFETCH_EN
    localparam bit PF = 1'b1;
`else
    localparam bit PF = 1'b0;
`endif

    typedef struct {
        bit          rst;
        bit          ack;
        bit          rdy;
        bit          rdr;
        logic [31:0] rpc;
        bit          ereq;
        logic [31:0] eaddr;
        bit          evld;
        logic [31:0] epc;
    } vec_t;

    vec_t tbl[$];

    instr_fetch dut (
        .clock       (clock),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .op          (op),
        .func        (func),
        .instr_pc    (instr_pc)
    );

    always #5 clock = ~clock;

    assign imem_rdata = ~imem_addr;

    function automatic vec_t mk(bit rst, bit ack, bit rdy, bit rdr, logic [31:0] rpc,
                                bit ereq, logic [31:0] eaddr, bit evld, logic [31:0] epc);
        vec_t v;
        v.rst = rst; v.ack = ack; v.rdy = rdy; v.rdr = rdr; v.rpc = rpc;
        v.ereq = ereq; v.eaddr = eaddr; v.evld = evld; v.epc = epc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_row(input int r, input vec_t v);
        logic [31:0] ei;
        string tag;
        tag = $sformatf("row%0d", r);
        ei  = ~v.epc;
        chk({tag, ".req"}, 32'(imem_req), 32'(v.ereq));
        if (v.ereq) chk({tag, ".addr"}, imem_addr, v.eaddr);
        chk({tag, ".valid"}, 32'(instr_valid), 32'(v.evld));
        if (v.evld) begin
            chk({tag, ".pc"}, instr_pc, v.epc);
            chk({tag, ".instr"}, instr, ei);
            chk({tag, ".op"}, 32'(op), 32'(ei[31:26]));
            chk({tag, ".func"}, 32'(func), 32'(ei[5:0]));
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset       = 1'b1;
        imem_ack    = 1'b0;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        int nreq;
        bit found;

        // Streaming fetch, memory acks every request immediately.
`ifdef FETCH_PREFETCH_EN
        tbl.push_back(mk(1, 1, 1, 0, 32'h0, 1, 32'h0,  0, 32'h0));
        tbl.push_back(mk(0, 1, 1, 0, 32'h0, 1, 32'h4,  1, 32'h0));
        tbl.push_back(mk(0, 1, 1, 0, 32'h0, 1, 32'h8,  1, 32'h4));
        tbl.push_back(mk(0, 1, 1, 0, 32'h0, 1, 32'hC,  1, 32'h8));
        tbl.push_back(mk(0, 0, 1, 0, 32'h0, 1, 32'h10, 1, 32'hC));
`else
        tbl.push_back(mk(1, 1, 1, 0, 32'h0, 1, 32'h0, 0, 32'h0));
        tbl.push_back(mk(0, 0, 1, 0, 32'h0, 0, 32'h0, 1, 32'h0));
        tbl.push_back(mk(0, 1, 1, 0, 32'h0, 1, 32'h4, 0, 32'h0));
        tbl.push_back(mk(0, 0, 1, 0, 32'h0, 0, 32'h0, 1, 32'h4));
        tbl.push_back(mk(0, 1, 1, 0, 32'h0, 1, 32'h8, 0, 32'h0));
        tbl.push_back(mk(0, 0, 1, 0, 32'h0, 0, 32'h0, 1, 32'h8));
`endif
        // Redirect with ack to 0x10, then redirect to 0x103 while 0x10 pending.
        tbl.push_back(mk(1, 1, 1, 1, 32'h10,  1, 32'h0,   0, 32'h0));
        tbl.push_back(mk(0, 0, 1, 1, 32'h103, 1, 32'h10,  0, 32'h0));
        tbl.push_back(mk(0, 1, 1, 0, 32'h0,   1, 32'h10,  0, 32'h0));
        tbl.push_back(mk(0, 1, 0, 0, 32'h0,   1, 32'h100, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,   PF, 32'h104, 1, 32'h100));
        // Redirect to the top word, PC wraps to zero.
        tbl.push_back(mk(1, 0, 1, 1, 32'hFFFF_FFFC, 1, 32'h0, 0, 32'h0));
        tbl.push_back(mk(0, 1, 1, 0, 32'h0, 1, 32'h0, 0, 32'h0));
        tbl.push_back(mk(0, 1, 1, 0, 32'h0, 1, 32'hFFFF_FFFC, 0, 32'h0));
        tbl.push_back(mk(0, PF, 1, 0, 32'h0, PF, 32'h0, 1, 32'hFFFF_FFFC));
        tbl.push_back(mk(0, !PF, 0, 0, 32'h0, 1, PF ? 32'h4 : 32'h0, PF, 32'h0));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0, PF, 32'h4, 1, 32'h0));

        // Reset values while reset is held.
        repeat (2) @(negedge clock);
        chk("rst.req", 32'(imem_req), 32'h0);
        chk("rst.valid", 32'(instr_valid), 32'h0);
        chk("rst.instr", instr, 32'h0);
        chk("rst.op", 32'(op), 32'h0);
        chk("rst.func", 32'(func), 32'h0);
        chk("rst.pc", instr_pc, 32'h0);
        reset = 1'b0;
        @(negedge clock);
        chk("first.req", 32'(imem_req), 32'h1);
        chk("first.addr", imem_addr, 32'h0);

        foreach (tbl[r]) begin
            if (tbl[r].rst) do_reset();
            @(negedge clock);
            check_row(r, tbl[r]);
            imem_ack    = tbl[r].ack;
            instr_ready = tbl[r].rdy;
            redirect    = tbl[r].rdr;
            redirect_pc = tbl[r].rpc;
        end

        // Decode stalled: request count limited by buffer depth.
        do_reset();
        nreq = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            imem_ack = imem_req;
            if (imem_req) nreq++;
        end
        @(negedge clock);
        chk("stall.nreq", 32'(nreq), PF ? 32'd2 : 32'd1);
        chk("stall.req", 32'(imem_req), 32'h0);
        chk("stall.valid", 32'(instr_valid), 32'h1);
        chk("stall.pc", instr_pc, 32'h0);

        // Ack held off for three cycles on the request to 0x8.
        do_reset();
        instr_ready = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clock);
            if (imem_req && imem_addr == 32'h8) begin
                found    = 1'b1;
                imem_ack = 1'b0;
            end else begin
                imem_ack = imem_req;
            end
        end
        chk("delay.found", 32'(found), 32'h1);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clock);
            chk($sformatf("delay%0d.req", k), 32'(imem_req), 32'h1);
            chk($sformatf("delay%0d.addr", k), imem_addr, 32'h8);
            imem_ack = (k == 3);
        end
        @(negedge clock);
        imem_ack = 1'b0;
        chk("delay.valid", 32'(instr_valid), 32'h1);
        chk("delay.pc", instr_pc, 32'h8);
        // Redirect together with a pop: buffer empty on the next cycle.
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        @(negedge clock);
        redirect = 1'b0;
        chk("rdpop.valid", 32'(instr_valid), 32'h0);
        chk("rdpop.req", 32'(imem_req), 32'h1);

        // Reset during a pending request, then a late ack.
        do_reset();
        @(negedge clock);
        chk("rmid.req", 32'(imem_req), 32'h1);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("rmid.req_drop", 32'(imem_req), 32'h0);
        @(negedge clock);
        imem_ack = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        imem_ack = 1'b0;
        chk("rmid.valid0", 32'(instr_valid), 32'h0);
        chk("rmid.req2", 32'(imem_req), 32'h1);
        chk("rmid.addr", imem_addr, 32'h0);
        @(negedge clock);
        chk("rmid.valid1", 32'(instr_valid), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
